switch_allocator: RTL and testbench
===================================

# switch_allocator

Per-router switch allocator for the minimal NoC. It takes the output-port selection that each `input_router` computes for the head flit at its input, arbitrates round-robin among inputs contending for the same output, and holds each output locked to its winning input until that input's tail flit has crossed. It drives the crossbar select lines and per-input grants. It sits between the five input modules and the router crossbar.

## Interface
Parameters:
- `NPORTS`, 5, number of router ports, covering inputs and outputs.
- `PSIZE`, 3, width of one port index. This matches the `vc_select` width.

Ports:
- `clk`, input, 1, the single clock for the block.
- `reset`, input, 1, asynchronous, active-high reset.
- `req_valid`, input, NPORTS, bit i means input i has a flit at its head.
- `req_port`, input, NPORTS*PSIZE, requested output for input i, in slice [i*PSIZE +: PSIZE]. This is driven from input i's `vc_select`.
- `req_tail`, input, NPORTS, bit i means input i's head flit is a packet tail. A single-flit packet has tail=1.
- `out_ready`, input, NPORTS, bit o means output o's downstream can accept a flit this cycle.
- `grant`, output, NPORTS, bit i means input i's head flit transfers this cycle, so input i pops.
- `xbar_sel`, output, NPORTS*PSIZE, for output o, slice [o*PSIZE +: PSIZE] gives the index of the input that drives it.
- `xbar_en`, output, NPORTS, bit o means output o carries a valid flit this cycle.
- `err_port`, output, 1, registered one-cycle pulse raised when any valid request carries an illegal port code.

## Operation
- Port codes: 0 = Local, 1 = North, 2 = East, 3 = South, 4 = West. Codes 5 to 7 are illegal.
  - Illegal requests are never granted.
  - The next cycle, `err_port` is 1.
- Each output o runs an independent FSM with state IDLE or LOCKED. LOCKED stores `owner[o]`.
- Each output also has a round-robin pointer `ptr[o]`. Reset value is 0.
- **IDLE:**
  - An input i is a candidate when `req_valid[i]` is 1, `req_port[i]==o`, and i is not the owner of another output.
  - Winner: the first candidate found scanning from `ptr[o]` upward, wrapping modulo NPORTS.
  - With no candidate, the output stays IDLE.
  - With a winner, at the clock edge the output moves to LOCKED with `owner[o]` set to the winner.
  - `out_ready` is not consulted during arbitration.
- **LOCKED, combinational outputs:**
  - `xbar_sel[o] = owner`.
  - `xbar_en[o] = req_valid[owner] & out_ready[o]`.
  - `grant[owner] = xbar_en[o]`.
- **LOCKED, release:**
  - A transfer occurs on a cycle where `xbar_en[o]` is 1.
  - If `req_tail[owner]` is 1 on that transfer, the next state is IDLE and `ptr[o] = (owner+1) mod NPORTS`.
  - Otherwise the output stays LOCKED.
- `req_port` is sampled only in IDLE. While LOCKED, body flits are forwarded regardless of their `req_port` value.
- A U-turn, where input index equals output index, is allowed and is not checked.

## Timing
- Reset values:
  - All FSMs are IDLE and all `ptr` are 0.
  - `grant`, `xbar_en`, `xbar_sel` and `err_port` are all 0.
- Head latency is 1 cycle. A request appearing in cycle N on an IDLE output is locked at the end of N, and grant can be asserted in N+1.
- Body throughput is 1 flit per cycle while `req_valid` and `out_ready` are both held at 1.
- Owner `req_valid` drops mid-packet: the output stays LOCKED with no grant and no `xbar_en`. It does not time out.
- `out_ready` is 0: grant and `xbar_en` are held at 0, and the lock is held.
- Tail transfer in cycle N: the output is IDLE in N+1 and arbitrates there. This is a mandatory one-cycle bubble between packets on the same output.
- Simultaneous candidates: only the winner is locked. Losers keep their requests, and the sender holds the flit.
- `reset` asserted mid-packet: all locks are dropped immediately and asynchronously, and outputs go to 0. Any partially sent packet is lost. Upstream flushing is out of scope.
- At most one bit of `grant` per output is set, and at most one output per input.

## Structure
- Shared package `noc_pkg` holds:
  - The port code constants: `PORT_L`, `PORT_N`, `PORT_E`, `PORT_S`, `PORT_W`.
  - The `NPORTS` and `PSIZE` constants.
  - The IDLE/LOCKED state encoding.
  - `input_router` uses the same constants.
- Sub-module `rr_arbiter`, instantiated once per output, contains:
  - The pointer register.
  - The priority scan.
  - The lock FSM.
  - The owner register.
- The top level contains:
  - Candidate mask generation.
  - OR-reduction of grants.
  - The `err_port` register.

## Test plan
- Reset, then input 0 requests port 2 with tail=1 and `out_ready`=all 1s.
  - Cycle N+1: `grant`=00001, `xbar_sel[2]`=0, `xbar_en`=00100.
  - Cycle N+2: output 2 is IDLE.
- Inputs 1, 3 and 4 all request port 1 with 3-flit packets.
  - Service order is 1, 3, 4.
  - Each packet has 3 consecutive grants, followed by 1 bubble cycle.
  - Afterwards `ptr[1]`=0.
- Input 2 holds a 4-flit packet to port 3, and `out_ready[3]` is 0 for cycles 2–3.
  - `grant[2]` is 0 during those cycles.
  - The lock is held, and all 4 flits are delivered in order.
- Input 0 sends to output 4 while input 1 sends to output 2, both at the same time.
  - Both are granted in the same cycle.
  - `xbar_sel[4]`=0 and `xbar_sel[2]`=1.
- Input 3 requests with `req_port`=6.
  - No grant.
  - `err_port`=1 for exactly 1 cycle.
  - All outputs stay IDLE.
- Input 0 is mid-packet and locked to port 1 when `reset` pulses.
  - All outputs go to 0 immediately.
  - After release, a new request from input 2 to port 1 wins, with `ptr[1]`=0.

Source files
------------

// File: rtl/noc_pkg.sv
// ============================================================================
// Module      : noc_pkg
// Description : Shared NoC constants: port codes, router sizing, lock states.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package noc_pkg;

    localparam int NPORTS = 5;
    localparam int PSIZE  = 3;

    localparam logic [PSIZE-1:0] PORT_L = 3'd0;
    localparam logic [PSIZE-1:0] PORT_N = 3'd1;
    localparam logic [PSIZE-1:0] PORT_E = 3'd2;
    localparam logic [PSIZE-1:0] PORT_S = 3'd3;
    localparam logic [PSIZE-1:0] PORT_W = 3'd4;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } lock_state_t;

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ============================================================================
// Module      : rr_arbiter
// Description : Per-output round-robin arbiter with packet lock until tail.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter #(
    parameter int NPORTS = noc_pkg::NPORTS,
    parameter int PSIZE  = noc_pkg::PSIZE
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NPORTS-1:0] cand,
    input  logic [NPORTS-1:0] req_valid,
    input  logic [NPORTS-1:0] req_tail,
    input  logic              out_ready,
    output logic              locked,
    output logic [PSIZE-1:0]  owner,
    output logic              xbar_en,
    output logic [NPORTS-1:0] grant
);
    import noc_pkg::*;

    lock_state_t      r_state, w_state_nxt;
    logic [PSIZE-1:0] r_owner, w_owner_nxt;
    logic [PSIZE-1:0] r_ptr, w_ptr_nxt;
    logic [PSIZE-1:0] w_winner;
    logic             w_found;
    logic             w_en;

    // Priority scan starting at the pointer, wrapping modulo NPORTS
    always_comb begin
        int idx;
        idx      = 0;
        w_found  = 1'b0;
        w_winner = '0;
        for (int k = 0; k < NPORTS; k++) begin
            idx = int'(r_ptr) + k;
            if (idx >= NPORTS) idx = idx - NPORTS;
            if (!w_found && cand[idx[PSIZE-1:0]]) begin
                w_found  = 1'b1;
                w_winner = idx[PSIZE-1:0];
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_ptr_nxt   = r_ptr;
        w_en        = 1'b0;
        grant       = '0;
        locked      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    w_state_nxt = ST_LOCKED;
                    w_owner_nxt = w_winner;
                end
            end
            ST_LOCKED: begin
                locked         = 1'b1;
                w_en           = req_valid[r_owner] & out_ready;
                grant[r_owner] = w_en;
                if (w_en && req_tail[r_owner]) begin
                    w_state_nxt = ST_IDLE;
                    w_ptr_nxt   = (r_owner == PSIZE'(NPORTS - 1)) ? '0 : r_owner + 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign xbar_en = w_en;
    assign owner   = r_owner;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_owner <= '0;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_owner <= w_owner_nxt;
            r_ptr   <= w_ptr_nxt;
        end
    end

endmodule

`default_nettype wire

// File: rtl/switch_allocator.sv
// ============================================================================
// Module      : switch_allocator
// Description : Router switch allocator: candidate masking, per-output locks,
//               crossbar selects, grant merge and illegal-port error flag.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module switch_allocator #(
    parameter int NPORTS = noc_pkg::NPORTS,
    parameter int PSIZE  = noc_pkg::PSIZE
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NPORTS-1:0]       req_valid,
    input  logic [NPORTS*PSIZE-1:0] req_port,
    input  logic [NPORTS-1:0]       req_tail,
    input  logic [NPORTS-1:0]       out_ready,
    output logic [NPORTS-1:0]       grant,
    output logic [NPORTS*PSIZE-1:0] xbar_sel,
    output logic [NPORTS-1:0]       xbar_en,
    output logic                    err_port
);
    logic [NPORTS-1:0] w_locked;
    logic [PSIZE-1:0]  w_owner     [NPORTS];
    logic [NPORTS-1:0] w_grant_vec [NPORTS];
    logic [NPORTS-1:0] w_cand      [NPORTS];
    logic [NPORTS-1:0] w_busy;
    logic              w_illegal;
    logic              r_err_port;

    // An input already owning a locked output may not contend elsewhere
    always_comb begin
        w_busy = '0;
        for (int o = 0; o < NPORTS; o++) begin
            for (int i = 0; i < NPORTS; i++) begin
                if (w_locked[o] && (w_owner[o] == PSIZE'(i))) w_busy[i] = 1'b1;
            end
        end
    end

    always_comb begin
        for (int o = 0; o < NPORTS; o++) begin
            w_cand[o] = '0;
            for (int i = 0; i < NPORTS; i++) begin
                w_cand[o][i] = req_valid[i] && !w_busy[i]
                            && (req_port[i*PSIZE +: PSIZE] == PSIZE'(o));
            end
        end
    end

    generate
        for (genvar o = 0; o < NPORTS; o++) begin : g_out
            rr_arbiter #(
                .NPORTS (NPORTS),
                .PSIZE  (PSIZE)
            ) u_arb (
                .clk       (clk),
                .reset     (reset),
                .cand      (w_cand[o]),
                .req_valid (req_valid),
                .req_tail  (req_tail),
                .out_ready (out_ready[o]),
                .locked    (w_locked[o]),
                .owner     (w_owner[o]),
                .xbar_en   (xbar_en[o]),
                .grant     (w_grant_vec[o])
            );
            assign xbar_sel[o*PSIZE +: PSIZE] = w_locked[o] ? w_owner[o] : '0;
        end
    endgenerate

    always_comb begin
        grant     = '0;
        w_illegal = 1'b0;
        for (int o = 0; o < NPORTS; o++) begin
            grant = grant | w_grant_vec[o];
        end
        for (int i = 0; i < NPORTS; i++) begin
            if (req_valid[i] && (req_port[i*PSIZE +: PSIZE] >= PSIZE'(NPORTS))) w_illegal = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_err_port <= 1'b0;
        else       r_err_port <= w_illegal;
    end

    assign err_port = r_err_port;

endmodule

`default_nettype wire

// File: tb/tb_switch_allocator.sv
// ============================================================================
// Module      : tb_switch_allocator
// Description : Scoreboard bench for switch_allocator with directed packets.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_switch_allocator;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  req_valid;
    logic [14:0] req_port;
    logic [4:0]  req_tail;
    logic [4:0]  out_ready;
    logic [4:0]  grant;
    logic [14:0] xbar_sel;
    logic [4:0]  xbar_en;
    logic        err_port;
    logic [2:0]  rp [5];

    assign req_port = {rp[4], rp[3], rp[2], rp[1], rp[0]};

    switch_allocator dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_port  (req_port),
        .req_tail  (req_tail),
        .out_ready (out_ready),
        .grant     (grant),
        .xbar_sel  (xbar_sel),
        .xbar_en   (xbar_en),
        .err_port  (err_port)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic [4:0]  g;
        logic [4:0]  en;
        logic [14:0] sel;
        logic        err;
    } exp_t;

    exp_t sb [$];
    exp_t m_e;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %0h, expected %0h", name, cyc, act, req);
        end
    endtask

    // Monitor: compare the scoreboard head whose cycle matches; otherwise demand silence
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc < cyc) begin
            n_checks++;
            n_fail++;
            $display("FAIL missed_expect cycle %0d: expected entry for cycle %0d never compared", cyc, sb[0].cyc);
            void'(sb.pop_front());
        end
        if (sb.size() > 0 && sb[0].cyc == cyc) begin
            m_e = sb.pop_front();
            chk("grant",    32'(grant),    32'(m_e.g));
            chk("xbar_en",  32'(xbar_en),  32'(m_e.en));
            chk("xbar_sel", 32'(xbar_sel), 32'(m_e.sel));
            chk("err_port", 32'(err_port), 32'(m_e.err));
        end else begin
            chk("idle_outputs", 32'({grant, xbar_en, err_port}), 32'd0);
        end
    end

    function automatic logic [14:0] sl(input int o, input int i);
        logic [14:0] r;
        r = 15'(i) << (o * 3);
        return r;
    endfunction

    task automatic step(input logic [4:0] v, input logic [4:0] t, input logic [4:0] rdy,
                        input logic [4:0] eg, input logic [4:0] een, input logic [14:0] es,
                        input logic eerr);
        req_valid = v;
        req_tail  = t;
        out_ready = rdy;
        sb.push_back('{cyc, eg, een, es, eerr});
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        req_valid = '0;
        req_tail  = '0;
        out_ready = '0;
        for (int i = 0; i < 5; i++) rp[i] = '0;
        #2;
        chk("reset_grant",    32'(grant),    32'd0);
        chk("reset_xbar_en",  32'(xbar_en),  32'd0);
        chk("reset_xbar_sel", 32'(xbar_sel), 32'd0);
        chk("reset_err_port", 32'(err_port), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // Single-flit packet, input 0 -> output 2
        rp[0] = 3'd2;
        step(5'b00001, 5'b00001, 5'b11111, 5'b00000, 5'b00000, 15'd0, 1'b0);
        step(5'b00001, 5'b00001, 5'b11111, 5'b00001, 5'b00100, sl(2, 0), 1'b0);
        step(5'b00000, 5'b00000, 5'b11111, 5'b00000, 5'b00000, 15'd0, 1'b0);

        // Inputs 1, 3, 4 contend for output 1 with 3-flit packets
        rp[1] = 3'd1; rp[3] = 3'd1; rp[4] = 3'd1;
        step(5'b11010, 5'b00000, 5'b11111, 5'b00000, 5'b00000, 15'd0, 1'b0);
        step(5'b11010, 5'b00000, 5'b11111, 5'b00010, 5'b00010, sl(1, 1), 1'b0);
        step(5'b11010, 5'b00000, 5'b11111, 5'b00010, 5'b00010, sl(1, 1), 1'b0);
        step(5'b11010, 5'b00010, 5'b11111, 5'b00010, 5'b00010, sl(1, 1), 1'b0);
        step(5'b11000, 5'b00000, 5'b11111, 5'b00000, 5'b00000, 15'd0, 1'b0);
        step(5'b11000, 5'b00000, 5'b11111, 5'b01000, 5'b00010, sl(1, 3), 1'b0);
        step(5'b11000, 5'b00000, 5'b11111, 5'b01000, 5'b00010, sl(1, 3), 1'b0);
        step(5'b11000, 5'b01000, 5'b11111, 5'b01000, 5'b00010, sl(1, 3), 1'b0);
        step(5'b10000, 5'b00000, 5'b11111, 5'b00000, 5'b00000, 15'd0, 1'b0);
        step(5'b10000, 5'b00000, 5'b11111, 5'b10000, 5'b00010, sl(1, 4), 1'b0);
        step(5'b10000, 5'b00000, 5'b11111, 5'b10000, 5'b00010, sl(1, 4), 1'b0);
        step(5'b10000, 5'b10000, 5'b11111, 5'b10000, 5'b00010, sl(1, 4), 1'b0);
        // Pointer back at 0: input 0 must beat input 4
        rp[0] = 3'd1;
        step(5'b10001, 5'b10001, 5'b11111, 5'b00000, 5'b00000, 15'd0, 1'b0);
        step(5'b10001, 5'b10001, 5'b11111, 5'b00001, 5'b00010, sl(1, 0), 1'b0);
        step(5'b10000, 5'b10000, 5'b11111, 5'b00000, 5'b00000, 15'd0, 1'b0);
        step(5'b10000, 5'b10000, 5'b11111, 5'b10000, 5'b00010, sl(1, 4), 1'b0);
        step(5'b00000, 5'b00000, 5'b11111, 5'b00000, 5'b00000, 15'd0, 1'b0);

        // 4-flit packet input 2 -> output 3 with two backpressure cycles
        rp[2] = 3'd3;
        step(5'b00100, 5'b00000, 5'b11111, 5'b00000, 5'b00000, 15'd0, 1'b0);
        step(5'b00100, 5'b00000, 5'b11111, 5'b00100, 5'b01000, sl(3, 2), 1'b0);
        step(5'b00100, 5'b00000, 5'b10111, 5'b00000, 5'b00000, sl(3, 2), 1'b0);
        step(5'b00100, 5'b00000, 5'b10111, 5'b00000, 5'b00000, sl(3, 2), 1'b0);
        step(5'b00100, 5'b00000, 5'b11111, 5'b00100, 5'b01000, sl(3, 2), 1'b0);
        step(5'b00100, 5'b00000, 5'b11111, 5'b00100, 5'b01000, sl(3, 2), 1'b0);
        step(5'b00100, 5'b00100, 5'b11111, 5'b00100, 5'b01000, sl(3, 2), 1'b0);
        step(5'b00000, 5'b00000, 5'b11111, 5'b00000, 5'b00000, 15'd0, 1'b0);

        // Concurrent transfers: input 0 -> output 4, input 1 -> output 2
        rp[0] = 3'd4; rp[1] = 3'd2;
        step(5'b00011, 5'b00011, 5'b11111, 5'b00000, 5'b00000, 15'd0, 1'b0);
        step(5'b00011, 5'b00011, 5'b11111, 5'b00011, 5'b10100, sl(4, 0) | sl(2, 1), 1'b0);
        step(5'b00000, 5'b00000, 5'b11111, 5'b00000, 5'b00000, 15'd0, 1'b0);

        // Illegal port code
        rp[3] = 3'd6;
        step(5'b01000, 5'b01000, 5'b11111, 5'b00000, 5'b00000, 15'd0, 1'b0);
        step(5'b00000, 5'b00000, 5'b11111, 5'b00000, 5'b00000, 15'd0, 1'b1);
        step(5'b00000, 5'b00000, 5'b11111, 5'b00000, 5'b00000, 15'd0, 1'b0);

        // Asynchronous reset in the middle of a packet on output 1
        rp[0] = 3'd1;
        step(5'b00001, 5'b00000, 5'b11111, 5'b00000, 5'b00000, 15'd0, 1'b0);
        step(5'b00001, 5'b00000, 5'b11111, 5'b00001, 5'b00010, sl(1, 0), 1'b0);
        sb.push_back('{cyc, 5'b00001, 5'b00010, sl(1, 0), 1'b0});
        #6;
        reset = 1'b1;
        #1;
        chk("async_reset_grant",    32'(grant),    32'd0);
        chk("async_reset_xbar_en",  32'(xbar_en),  32'd0);
        chk("async_reset_xbar_sel", 32'(xbar_sel), 32'd0);
        chk("async_reset_err_port", 32'(err_port), 32'd0);
        @(posedge clk);
        #1;
        req_valid = '0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        rp[2] = 3'd1; rp[4] = 3'd1;
        step(5'b10100, 5'b10100, 5'b11111, 5'b00000, 5'b00000, 15'd0, 1'b0);
        step(5'b10100, 5'b10100, 5'b11111, 5'b00100, 5'b00010, sl(1, 2), 1'b0);
        step(5'b10000, 5'b10000, 5'b11111, 5'b00000, 5'b00000, 15'd0, 1'b0);
        step(5'b10000, 5'b10000, 5'b11111, 5'b10000, 5'b00010, sl(1, 4), 1'b0);
        step(5'b00000, 5'b00000, 5'b11111, 5'b00000, 5'b00000, 15'd0, 1'b0);

        repeat (2) @(posedge clk);
        #1;
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
